// File: rtl/axi_slv_pkg.sv
// -----------------------------------------------------------------------------
// axi_slv_pkg
// Shared types and constants for the AXI3 responder memory (axi_slave_mem).
//   burst_t          : AXI burst encoding
//   RESP_OKAY/SLVERR : B/R response codes
//   W_* / R_*        : write and read FSM state encodings
//   burst_bad()      : reserved burst, or WRAP with an illegal length
//   burst_eff()      : burst type actually used for address generation
// -----------------------------------------------------------------------------
package axi_slv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write FSM states
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Read FSM states
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // WRAP is only legal for 2, 4, 8 or 16 beats.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [3:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

  // Bad bursts still run to completion, stepping as INCR.
  function automatic burst_t burst_eff(input logic [1:0] burst, input logic [3:0] len);
    return burst_bad(burst, len) ? BURST_INCR : burst_t'(burst);
  endfunction

endpackage

// File: rtl/axi_slv_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_slv_addr_gen
// Combinational next-beat address for one AXI burst.
//   addr      in  32 current beat byte address
//   size      in  3  log2 bytes per beat (already clamped by the caller)
//   len       in  4  beats minus one
//   burst     in  2  effective burst type (FIXED/INCR/WRAP only)
//   next_addr out 32 byte address of the following beat
// -----------------------------------------------------------------------------
module axi_slv_addr_gen
  import axi_slv_pkg::*;
(
  input  logic   [31:0] addr,
  input  logic   [2:0]  size,
  input  logic   [3:0]  len,
  input  burst_t        burst,
  output logic   [31:0] next_addr
);

  logic [31:0] step;
  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;

  assign step      = 32'd1 << size;
  assign incr_addr = addr + step;
  // Wrap window is the total burst size in bytes; always a power of two here.
  assign wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem.sv
// -----------------------------------------------------------------------------
// axi_slave_mem
// AXI3 responder with an internal register-array memory. Independent write
// (AW/W/B) and read (AR/R) paths, one outstanding burst each.
//   aclk, arst            clock (rising edge) / async active-low reset
//   aw*  / awready        write address channel
//   w*   / wready         write data channel (termination by beat count)
//   bid, bresp, bvalid    write response channel, bready from master
//   ar*  / arready        read address channel
//   rid, rdata, rresp,    read data channel, rready from master
//   rlast, rvalid
// Optional build macro AXI_SLV_ADDR_CHECK_EN: beats whose word index falls
// outside the memory are dropped (writes) or return zero (reads) with SLVERR.
// Without it the word index wraps modulo MEM_WORDS.
// -----------------------------------------------------------------------------
module axi_slave_mem
  import axi_slv_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 1024
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic [ID_W-1:0]     awid,
  input  logic [31:0]         awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [31:0]         araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam int         SH       = $clog2(STRB_W);
  localparam int         IDX_W    = $clog2(MEM_WORDS);
  localparam logic [2:0] MAX_SIZE = 3'(SH);

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic              rst_done;

  // Write path
  logic [1:0]       w_state;
  logic [ID_W-1:0]  w_id;
  logic [31:0]      w_addr, w_next;
  logic [3:0]       w_len, w_cnt;
  logic [2:0]       w_size;
  burst_t           w_burst;
  logic             w_err, w_oor, w_beat_err, w_last_beat;
  logic [IDX_W-1:0] w_idx;

  // Read path
  logic [0:0]       r_state;
  logic [31:0]      r_addr, r_next;
  logic [3:0]       r_len, r_cnt;
  logic [2:0]       r_size;
  burst_t           r_burst;
  logic             r_err, r_oor;
  logic [IDX_W-1:0] r_idx;

  assign w_idx = w_addr[SH +: IDX_W];
  assign r_idx = r_addr[SH +: IDX_W];

`ifdef AXI_SLV_ADDR_CHECK_EN
  assign w_oor = (w_addr >> (SH + IDX_W)) != 32'd0;
  assign r_oor = (r_addr >> (SH + IDX_W)) != 32'd0;
`else
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif

  // Holds both ready outputs low for the first edge after reset release.
  always_ff @(posedge aclk or negedge arst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!arst) rst_done <= 1'b0;
    else       rst_done <= 1'b1;
  end

  // ---------------------------------------------------------------- write ---
  axi_slv_addr_gen u_w_addr_gen (
    .addr      (w_addr),
    .size      (w_size),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next)
  );

  assign awready     = rst_done && (w_state == W_IDLE);
  assign wready      = (w_state == W_DATA);
  assign bvalid      = (w_state == W_RESP);
  assign w_last_beat = (w_cnt == w_len);
  // wlast must coincide with the counted last beat; it never ends the burst.
  assign w_beat_err  = (wlast != w_last_beat) || w_oor;

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= BURST_INCR;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid && awready) begin
          w_id    <= awid;
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_size  <= (awsize > MAX_SIZE) ? MAX_SIZE : awsize;
          w_burst <= burst_eff(awburst, awlen);
          w_err   <= burst_bad(awburst, awlen) || (awsize > MAX_SIZE);
          w_cnt   <= '0;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_addr <= w_next;
          w_cnt  <= w_cnt + 4'd1;
          w_err  <= w_err || w_beat_err;
          if (w_last_beat) begin
            w_state <= W_RESP;
            bid     <= w_id;
            bresp   <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the memory array has no reset; contents survive arst and only the FSMs restart.
  always_ff @(posedge aclk) begin
    if (wready && wvalid && !w_oor) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read ---
  axi_slv_addr_gen u_r_addr_gen (
    .addr      (r_addr),
    .size      (r_size),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (r_next)
  );

  assign arready = rst_done && (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);
  assign rlast   = rvalid && (r_cnt == r_len);
  // Asynchronous array read: a write to the same word at this edge is not yet visible.
  assign rdata   = (rvalid && !r_oor) ? mem[r_idx] : '0;
  assign rresp   = (rvalid && (r_err || r_oor)) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      r_state <= R_IDLE;
      rid     <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= BURST_INCR;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid && arready) begin
          rid     <= arid;
          r_addr  <= araddr;
          r_len   <= arlen;
          r_size  <= (arsize > MAX_SIZE) ? MAX_SIZE : arsize;
          r_burst <= burst_eff(arburst, arlen);
          r_err   <= burst_bad(arburst, arlen) || (arsize > MAX_SIZE);
          r_cnt   <= '0;
          r_state <= R_DATA;
        end
        R_DATA: if (rready) begin
          r_err <= r_err || r_oor;
          if (rlast) begin
            r_state <= R_IDLE;
          end else begin
            r_addr <= r_next;
            r_cnt  <= r_cnt + 4'd1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
